updown_counter_param: RTL



---
 rtl/updown_pkg.sv | 11 +
 rtl/updown_next.sv | 56 +++++
 rtl/updown_counter_param.sv | 74 +++++++
 3 files changed

// File: rtl/updown_pkg.sv
// Shared types and defaults for the parametrised up/down counter.
package updown_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } count_mode_e;

    localparam int unsigned DEF_WIDTH = 8;

endpackage : updown_pkg

// File: rtl/updown_next.sv
// Combinational next-count and overflow/underflow compute for updown_counter_param.
module updown_next
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter count_mode_e MODE  = CNT_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count_next,
    output logic             ovf,
    output logic             unf,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Inverted limits disable counting but never block a load.
    always_comb begin
        cfg_err = (min_val > max_val);
    end

    // Priority: load, then hold conditions, then increment, then decrement.
    // Limit checks precede +1/-1 so the arithmetic never wraps mod 2^WIDTH.
    always_comb begin
        count_next = count;
        ovf        = 1'b0;
        unf        = 1'b0;
        if (load) begin
            count_next = load_val;
        end else if (en && (up != down) && !cfg_err) begin
            if (up) begin
                if (count < max_val) begin
                    count_next = count + ONE;
                end else begin
                    count_next = (MODE == CNT_SAT) ? max_val : min_val;
                    ovf        = 1'b1;
                end
            end else begin
                if (count > min_val) begin
                    count_next = count - ONE;
                end else begin
                    count_next = (MODE == CNT_SAT) ? min_val : max_val;
                    unf        = 1'b1;
                end
            end
        end
    end

endmodule : updown_next

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate mode, runtime limits,
// synchronous load, terminal-count flags and registered overflow/underflow pulses.
module updown_counter_param
    import updown_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter count_mode_e      MODE    = CNT_WRAP,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] min_val,
    input  logic [WIDTH-1:0] max_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             overflow,
    output logic             underflow,
    output logic             cfg_err
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             underflow_q;
    logic             underflow_d;

    updown_next #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .count      (count_q),
        .en         (en),
        .up         (up),
        .down       (down),
        .load       (load),
        .load_val   (load_val),
        .min_val    (min_val),
        .max_val    (max_val),
        .count_next (count_d),
        .ovf        (overflow_d),
        .unf        (underflow_d),
        .cfg_err    (cfg_err)
    );

    // Count and event pulses update together; reset aborts any pending pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q     <= RST_VAL;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Terminal-count flags track the live limits against the registered count.
    always_comb begin
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        at_max    = (count_q >= max_val);
        at_min    = (count_q <= min_val);
    end

endmodule : updown_counter_param
